// File: rtl/redmule_pkg.sv
// Shared constants and FSM state type for the MX (FP8 E4M3 + E8M0) encoder.
package redmule_pkg;

  localparam int unsigned MX_ELEM_W = 8;
  localparam int unsigned FP8_BIAS  = 7;
  localparam int unsigned FP16_BIAS = 15;
  localparam int unsigned E8M0_BIAS = 127;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ENCODE  = 2'd1,
    OUTPUT  = 2'd2
  } enc_state_e;

endpackage

// File: rtl/redmule_mx_fp16_to_fp8.sv
// Single-lane FP16 -> FP8 E4M3 conversion relative to a shared block exponent.
// Macro REDMULE_MX_ENC_RNE_EN selects round-to-nearest-even; otherwise the
// mantissa is truncated.
module redmule_mx_fp16_to_fp8
  import redmule_pkg::*;
(
  input  logic [15:0] elem_i,
  input  logic [4:0]  emax_i,
  output logic [7:0]  fp8_o
);

  // The block maximum lands on the largest normal E4M3 exponent
  localparam int unsigned FP8_EMAX = 2 * FP8_BIAS;

  logic              w_sign;
  logic [4:0]        w_e16;
  logic [9:0]        w_m16;
  logic signed [6:0] w_e8;
`ifdef REDMULE_MX_ENC_RNE_EN
  logic              w_round_up;
  logic [3:0]        w_mant_r;
`endif

  assign w_sign = elem_i[15];
  assign w_e16  = elem_i[14:10];
  assign w_m16  = elem_i[9:0];
  assign w_e8   = 7'({2'b00, w_e16}) - 7'({2'b00, emax_i}) + 7'(FP8_EMAX);

`ifdef REDMULE_MX_ENC_RNE_EN
  assign w_round_up = w_m16[6] & (w_m16[7] | (|w_m16[5:0]));
  assign w_mant_r   = {1'b0, w_m16[9:7]} + {3'b000, w_round_up};
`endif

  // Classify the element and form the E4M3 byte
  always_comb begin
    fp8_o = {w_sign, 7'b0};
    if (w_e16 == 5'd0) begin
      fp8_o = {w_sign, 7'b0};
    end else if (w_e16 == 5'h1F) begin
      fp8_o = (w_m16 != 10'd0) ? {w_sign, 4'hF, 3'b100} : {w_sign, 4'hF, 3'b000};
    end else begin
`ifdef REDMULE_MX_ENC_RNE_EN
      if (w_e8 < 7'sd0) begin
        fp8_o = {w_sign, 7'b0};
      end else if (w_e8 == 7'sd0) begin
        // Only a mantissa carry lifts an e8=0 value into the normal range
        fp8_o = w_mant_r[3] ? {w_sign, 4'h1, 3'b000} : {w_sign, 7'b0};
      end else if (w_mant_r[3]) begin
        fp8_o = (w_e8[3:0] == 4'hE) ? {w_sign, 4'hE, 3'b111}
                                    : {w_sign, w_e8[3:0] + 4'd1, 3'b000};
      end else begin
        fp8_o = {w_sign, w_e8[3:0], w_mant_r[2:0]};
      end
`else
      if (w_e8 <= 7'sd0) begin
        fp8_o = {w_sign, 7'b0};
      end else begin
        fp8_o = {w_sign, w_e8[3:0], w_m16[9:7]};
      end
`endif
    end
  end

endmodule

// File: rtl/redmule_mx_encoder.sv
// Collects NUM_ELEMS FP16 elements, derives a shared E8M0 exponent from the
// largest normal exponent, and emits the packed FP8 E4M3 block on two
// independent valid/ready channels.
// Macro REDMULE_MX_ENC_RNE_EN (see redmule_mx_fp16_to_fp8) enables RNE.
module redmule_mx_encoder
  import redmule_pkg::*;
#(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned BITW   = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              fp16_valid_i,
  output logic              fp16_ready_o,
  input  logic [BITW-1:0]   fp16_data_i,
  output logic              mx_val_valid_o,
  input  logic              mx_val_ready_i,
  output logic [DATA_W-1:0] mx_val_data_o,
  output logic              mx_exp_valid_o,
  input  logic              mx_exp_ready_i,
  output logic [7:0]        mx_exp_data_o
);

  localparam int unsigned NUM_ELEMS = DATA_W / MX_ELEM_W;
  localparam int unsigned IDX_W     = $clog2(NUM_ELEMS);
  localparam int unsigned EXP_OFS   = E8M0_BIAS - FP16_BIAS - FP8_BIAS;

  enc_state_e        r_state, w_next_state;
  logic [IDX_W-1:0]  r_idx;
  logic [4:0]        r_emax;
  logic [BITW-1:0]   r_elems [NUM_ELEMS];
  logic              r_val_valid, r_exp_valid;
  logic [DATA_W-1:0] r_val_data, w_packed;
  logic [7:0]        r_exp_data, w_exp;
  logic [4:0]        w_in_e16;
  logic              w_in_hs, w_last, w_out_done;

  assign w_in_hs    = fp16_valid_i & fp16_ready_o;
  assign w_last     = w_in_hs && (r_idx == IDX_W'(NUM_ELEMS - 1));
  assign w_in_e16   = fp16_data_i[14:10];
  assign w_out_done = (!r_val_valid || mx_val_ready_i) && (!r_exp_valid || mx_exp_ready_i);
  assign w_exp      = (r_emax == 5'd0) ? 8'(E8M0_BIAS) : 8'({3'b000, r_emax}) + 8'(EXP_OFS);

  assign mx_val_valid_o = r_val_valid;
  assign mx_val_data_o  = r_val_data;
  assign mx_exp_valid_o = r_exp_valid;
  assign mx_exp_data_o  = r_exp_data;

  for (genvar g = 0; g < NUM_ELEMS; g++) begin : g_lane
    redmule_mx_fp16_to_fp8 u_lane (
      .elem_i (r_elems[g]),
      .emax_i (r_emax),
      .fp8_o  (w_packed[g*MX_ELEM_W +: MX_ELEM_W])
    );
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= COLLECT;
    else         r_state <= w_next_state;
  end

  // Next-state and input-ready decode
  always_comb begin
    w_next_state = r_state;
    fp16_ready_o = 1'b0;
    case (r_state)
      COLLECT: begin
        fp16_ready_o = 1'b1;
        if (w_last) w_next_state = ENCODE;
      end
      ENCODE:  w_next_state = OUTPUT;
      OUTPUT:  if (w_out_done) w_next_state = COLLECT;
      default: w_next_state = COLLECT;
    endcase
  end

  // Element capture, running emax, output registers and channel handshakes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx       <= '0;
      r_emax      <= '0;
      r_val_valid <= 1'b0;
      r_exp_valid <= 1'b0;
      r_val_data  <= '0;
      r_exp_data  <= '0;
      for (int unsigned i = 0; i < NUM_ELEMS; i++) r_elems[i] <= '0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_in_hs) begin
            r_elems[r_idx] <= fp16_data_i;
            r_idx          <= r_idx + IDX_W'(1);
            if (w_in_e16 != 5'd0 && w_in_e16 != 5'h1F && w_in_e16 > r_emax)
              r_emax <= w_in_e16;
          end
        end
        ENCODE: begin
          r_val_data  <= w_packed;
          r_exp_data  <= w_exp;
          r_val_valid <= 1'b1;
          r_exp_valid <= 1'b1;
        end
        OUTPUT: begin
          if (r_val_valid && mx_val_ready_i) r_val_valid <= 1'b0;
          if (r_exp_valid && mx_exp_ready_i) r_exp_valid <= 1'b0;
          if (w_out_done) begin
            r_idx  <= '0;
            r_emax <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_redmule_mx_encoder.sv
// Self-checking bench for redmule_mx_encoder: directed blocks, backpressure,
// mid-block reset and randomized blocks against an arithmetic reference model.
module tb_redmule_mx_encoder;

  localparam int NE = 32;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         fp16_valid_i;
  logic         fp16_ready_o;
  logic [15:0]  fp16_data_i;
  logic         mx_val_valid_o;
  logic         mx_val_ready_i;
  logic [255:0] mx_val_data_o;
  logic         mx_exp_valid_o;
  logic         mx_exp_ready_i;
  logic [7:0]   mx_exp_data_o;

  logic [15:0]  blk [NE];
  logic [255:0] exp_data;
  logic [7:0]   exp_e;
  int           checks = 0;
  int           errors = 0;

  redmule_mx_encoder #(.DATA_W(256), .BITW(16)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .fp16_valid_i   (fp16_valid_i),
    .fp16_ready_o   (fp16_ready_o),
    .fp16_data_i    (fp16_data_i),
    .mx_val_valid_o (mx_val_valid_o),
    .mx_val_ready_i (mx_val_ready_i),
    .mx_val_data_o  (mx_val_data_o),
    .mx_exp_valid_o (mx_exp_valid_o),
    .mx_exp_ready_i (mx_exp_ready_i),
    .mx_exp_data_o  (mx_exp_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Value-level conversion straight from the format rules
  function automatic logic [7:0] ref_fp8(input logic [15:0] x, input int emax);
    int s, e, m, e8, mant;
    s = int'(x[15]); e = int'(x[14:10]); m = int'(x[9:0]);
    if (e == 0)  return 8'(s * 128);
    if (e == 31) return 8'(s * 128 + (m != 0 ? 8'h7C : 8'h78));
    e8   = e - emax + 14;
    mant = m / 128;
`ifdef REDMULE_MX_ENC_RNE_EN
    if ((m % 128) > 64 || ((m % 128) == 64 && (mant % 2) == 1)) mant++;
    if (mant == 8) begin mant = 0; e8++; end
    if (e8 <= 0)  return 8'(s * 128);
    if (e8 >= 15) return 8'(s * 128 + 8'h77);
`else
    if (e8 <= 0) return 8'(s * 128);
`endif
    return 8'(s * 128 + e8 * 8 + mant);
  endfunction

  task automatic ref_model();
    int emax, e;
    emax = 0;
    foreach (blk[i]) begin
      e = int'(blk[i][14:10]);
      if (e >= 1 && e <= 30 && e > emax) emax = e;
    end
    exp_e = (emax == 0) ? 8'd127 : 8'(emax + 105);
    for (int i = 0; i < NE; i++) exp_data[8*i +: 8] = ref_fp8(blk[i], emax);
  endtask

  task automatic send_block(input int n, input bit gaps);
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        fp16_valid_i = 1'b0;
        @(negedge clk_i);
      end
      fp16_valid_i = 1'b1;
      fp16_data_i  = blk[i];
      t = 0;
      while (!fp16_ready_o && t < 50) begin @(negedge clk_i); t++; end
      if (t >= 50) chk("in_ready_timeout", {255'b0, fp16_ready_o}, 256'd1);
      @(negedge clk_i);
    end
    fp16_valid_i = 1'b0;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!(mx_val_valid_o && mx_exp_valid_o) && t < 20) begin @(negedge clk_i); t++; end
    if (t >= 20) chk("out_valid_timeout", {255'b0, mx_val_valid_o & mx_exp_valid_o}, 256'd1);
  endtask

  task automatic run_and_check(input string tag);
    ref_model();
    send_block(NE, 1'b1);
    chk({tag, "_ready_encode"}, {255'b0, fp16_ready_o}, 256'd0);
    wait_valid();
    chk({tag, "_exp"}, {248'b0, mx_exp_data_o}, {248'b0, exp_e});
    chk({tag, "_data"}, mx_val_data_o, exp_data);
    chk({tag, "_ready_output"}, {255'b0, fp16_ready_o}, 256'd0);
    mx_val_ready_i = 1'b1;
    mx_exp_ready_i = 1'b1;
    @(negedge clk_i);
    chk({tag, "_valids_drop"}, {254'b0, mx_val_valid_o, mx_exp_valid_o}, 256'd0);
    chk({tag, "_ready_collect"}, {255'b0, fp16_ready_o}, 256'd1);
    mx_val_ready_i = 1'b0;
    mx_exp_ready_i = 1'b0;
  endtask

  task automatic random_block();
    int cls;
    for (int i = 0; i < NE; i++) begin
      cls = int'($urandom_range(11));
      blk[i][15]    = 1'($urandom_range(1));
      blk[i][9:0]   = 10'($urandom);
      case (cls)
        0:       blk[i][14:10] = 5'd0;
        1:       begin blk[i][14:10] = 5'd0; blk[i][9:0] = 10'd0; end
        2:       begin blk[i][14:10] = 5'h1F; blk[i][9:0] = 10'd0; end
        3:       begin blk[i][14:10] = 5'h1F; blk[i][9] = 1'b1; end
        4, 5, 6: blk[i][14:10] = 5'($urandom_range(30, 1));
        default: blk[i][14:10] = 5'($urandom_range(20, 12));
      endcase
    end
  endtask

  initial begin
    logic [255:0] held;
    logic [7:0]   rne_byte;
    bit           spurious;

    rst_ni = 1'b0; fp16_valid_i = 1'b0; fp16_data_i = '0;
    mx_val_ready_i = 1'b0; mx_exp_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_valids", {254'b0, mx_val_valid_o, mx_exp_valid_o}, 256'd0);
    chk("rst_val_data", mx_val_data_o, 256'd0);
    chk("rst_exp_data", {248'b0, mx_exp_data_o}, 256'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", {255'b0, fp16_ready_o}, 256'd1);

    // All ones
    foreach (blk[i]) blk[i] = 16'h3C00;
    run_and_check("ones");
    chk("ones_const_exp", {248'b0, exp_e}, 256'h78);
    chk("ones_const_byte", {248'b0, exp_data[7:0]}, 256'h70);

    // One larger element sets the scale
    foreach (blk[i]) blk[i] = 16'h3C00;
    blk[0] = 16'h4400;
    run_and_check("scale");
    chk("scale_const", {240'b0, exp_data[15:0]}, 256'h6070);

    // Special values and flush
    foreach (blk[i]) blk[i] = 16'h0000;
    blk[0] = 16'h7800; blk[1] = 16'h0400; blk[2] = 16'h8400;
    blk[3] = 16'h7C00; blk[4] = 16'h7E00;
    run_and_check("special");
    chk("special_const", {216'b0, exp_data[39:0]}, 256'h7C78800070);

    // All zero block
    foreach (blk[i]) blk[i] = 16'h0000;
    run_and_check("zeros");
    chk("zeros_const_exp", {248'b0, exp_e}, 256'h7F);

    // Rounding-sensitive mantissa
    foreach (blk[i]) blk[i] = 16'h3CC0;
`ifdef REDMULE_MX_ENC_RNE_EN
    rne_byte = 8'h72;
`else
    rne_byte = 8'h71;
`endif
    run_and_check("round");
    chk("round_byte31", {248'b0, mx_val_data_o[255:248]}, {248'b0, rne_byte});

    // Backpressure on the value channel only
    random_block();
    ref_model();
    send_block(NE, 1'b0);
    mx_exp_ready_i = 1'b1;
    wait_valid();
    chk("bp_exp", {248'b0, mx_exp_data_o}, {248'b0, exp_e});
    chk("bp_data", mx_val_data_o, exp_data);
    held = mx_val_data_o;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      chk("bp_exp_valid_low", {255'b0, mx_exp_valid_o}, 256'd0);
      chk("bp_val_valid_held", {255'b0, mx_val_valid_o}, 256'd1);
      chk("bp_val_stable", mx_val_data_o, held);
      chk("bp_ready_low", {255'b0, fp16_ready_o}, 256'd0);
    end
    mx_exp_ready_i = 1'b0;
    mx_val_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_val_done", {255'b0, mx_val_valid_o}, 256'd0);
    chk("bp_ready_collect", {255'b0, fp16_ready_o}, 256'd1);
    mx_val_ready_i = 1'b0;

    // Backpressure on the exponent channel only
    random_block();
    ref_model();
    send_block(NE, 1'b0);
    mx_val_ready_i = 1'b1;
    wait_valid();
    chk("bpx_data", mx_val_data_o, exp_data);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("bpx_val_valid_low", {255'b0, mx_val_valid_o}, 256'd0);
      chk("bpx_exp_held", {247'b0, mx_exp_valid_o, mx_exp_data_o}, {247'b0, 1'b1, exp_e});
      chk("bpx_ready_low", {255'b0, fp16_ready_o}, 256'd0);
    end
    mx_val_ready_i = 1'b0;
    mx_exp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bpx_exp_done", {255'b0, mx_exp_valid_o}, 256'd0);
    chk("bpx_ready_collect", {255'b0, fp16_ready_o}, 256'd1);
    mx_exp_ready_i = 1'b0;

    // Reset in the middle of a block
    random_block();
    send_block(10, 1'b0);
    rst_ni = 1'b0;
    #1;
    chk("midrst_valids", {254'b0, mx_val_valid_o, mx_exp_valid_o}, 256'd0);
    chk("midrst_data", {mx_val_data_o[255:8], mx_exp_data_o}, 256'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    spurious = 1'b0;
    mx_val_ready_i = 1'b1;
    mx_exp_ready_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (mx_val_valid_o || mx_exp_valid_o || !fp16_ready_o) spurious = 1'b1;
    end
    mx_val_ready_i = 1'b0;
    mx_exp_ready_i = 1'b0;
    chk("midrst_no_output", {255'b0, spurious}, 256'd0);
    random_block();
    run_and_check("after_rst");

    // Randomized blocks
    for (int b = 0; b < 8; b++) begin
      random_block();
      run_and_check("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
